move_scheduler: RTL and testbench
=================================

# move_scheduler

Beat-paced game controller that drives the move generator and judges player input for the FPGA dance game. Once per beat it requests the next move, presents that move as the active target for a bounded hit window, and scores the player's button presses against it. It sits between the move generator and the display/score logic. It also owns the generator's reset, so a song always starts from step 0.

## Interface
- BEAT_CYCLES, 25_000_000 — clk cycles per beat; min 16.
- PULSE_CYCLES, 4 — high time of gen_get_move, in cycles; min 1.
- WINDOW_CYCLES, 12_500_000 — hit window length; requires PULSE_CYCLES+2+WINDOW_CYCLES ≤ BEAT_CYCLES.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a song.
- btn  in  4  debounced level buttons, bit0=UP, bit1=DOWN, bit2=LEFT, bit3=RIGHT.
- gen_move  in  2  generator move (0 UP, 1 DOWN, 2 LEFT, 3 RIGHT).
- gen_end  in  1  generator last-move flag.
- gen_get_move  out  1  registered request pulse; generator advances on its rising edge.
- gen_reset  out  1  active-high generator reset.
- target  out  2  current move; valid only when target_valid=1.
- target_valid  out  1  high while the hit window is open.
- hit, miss  out  1 each  single-cycle judgment pulses.
- score  out  8  hit count, saturating at 255.
- combo  out  8  consecutive hits, saturating at 255.
- busy  out  1  song in progress.
- done  out  1  high after the last move is judged, until the next start.

## Operation
- States: IDLE, START, FETCH, SETTLE, ARMED, GAP, DONE.
- IDLE/DONE + start → START. start is ignored in every other state.
- START: hold gen_reset high for 2 cycles and clear score, combo, done and beat_cnt. Then go to FETCH.
- beat_cnt counts 0..BEAT_CYCLES-1 and wraps. It runs in every state except IDLE, START and DONE.
- FETCH: hold gen_get_move high for PULSE_CYCLES cycles. Then go to SETTLE.
- SETTLE: gen_get_move low for 1 cycle; latch gen_move into target and gen_end into last. Then go to ARMED.
- ARMED: target_valid=1 and the window counter runs. Each cycle, judge on a btn rising edge (btn & ~btn_q):
  - exactly the target bit rises → hit, score+1, combo+1;
  - any other bit rises, including target plus another in the same cycle → miss, combo=0;
  - no edge for WINDOW_CYCLES cycles → miss on the cycle after the last window cycle, combo=0.
- After judgment: target_valid drops. If last=1 go to DONE, else go to GAP.
- GAP → FETCH when beat_cnt wraps to 0.
- Buttons held across a window boundary produce no edge, so a held button never scores.
- DONE: busy=0, done=1. score and combo hold their values.
- Reset values: gen_get_move 0, gen_reset 1, target 0, target_valid 0, hit 0, miss 0, score 0, combo 0, busy 0, done 0, state IDLE.
- reset_n asserted mid-song: all outputs take reset values immediately, and the generator is held in reset via gen_reset=1.

## Timing
- gen_reset deasserts on the first clk edge after reset_n is released. In IDLE it stays 0.
- The first FETCH begins the cycle after START ends. beat_cnt=0 in that cycle.
- gen_get_move rises at beat cycle 0 and falls at beat cycle PULSE_CYCLES.
- target_valid rises at beat cycle PULSE_CYCLES+1.
- Judgment latency: hit/miss is asserted the cycle after the btn edge is sampled. target_valid falls in that same cycle.
- An edge sampled on the last window cycle counts.
- busy=1 from the START entry cycle through the final judgment cycle.

## Configuration
- MOVE_SCHED_COMBO_EN defined: combo counter present as described.
- Not defined: combo is tied to 0, no combo register is synthesized, and all other behaviour is identical.

## Test plan
Bench settings: BEAT_CYCLES=32, PULSE_CYCLES=2, WINDOW_CYCLES=8, driven by the team's move generator.
- Reset release, then start pulse → gen_reset high for 2 cycles. First target=0 (UP) with target_valid at beat cycle 3.
- Press the matching bit 2 cycles into each of the 16 windows → 16 hit pulses, score=16, combo=16, done=1, busy=0. Exactly 16 gen_get_move pulses are issued.
- No presses → 16 miss pulses, each 8 cycles after target_valid rises. score=0, combo=0.
- Hits on moves 1–3, then btn=4'b0011 edge on move 4 (RIGHT) → miss, combo=0, score=3. Next hit → combo=1.
- Hold UP from before window 1 → miss on window 1. Release and re-press in window 3 (UP) → hit.
- reset_n low mid-song at move 7 → all outputs return to reset values. A new start restarts at UP with score=0.

Source files
------------

// File: rtl/move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : move_scheduler
// Brief    : Beat-paced dance-game controller. Requests one move per beat,
//            opens a bounded hit window on it and scores button presses.
//            Define MOVE_SCHED_COMBO_EN to build the consecutive-hit counter.
// Revision : 1.0 - initial release
// ============================================================================
module move_scheduler #(
  parameter int BEAT_CYCLES   = 25_000_000,
  parameter int PULSE_CYCLES  = 4,
  parameter int WINDOW_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic [1:0] gen_move,
  input  logic       gen_end,
  output logic       gen_get_move,
  output logic       gen_reset,
  output logic [1:0] target,
  output logic       target_valid,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score,
  output logic [7:0] combo,
  output logic       busy,
  output logic       done
);

  localparam int c_BEAT_W  = $clog2(BEAT_CYCLES);
  localparam int c_PULSE_W = $clog2(PULSE_CYCLES + 1);
  localparam int c_WIN_W   = $clog2(WINDOW_CYCLES + 1);

  localparam logic [c_BEAT_W-1:0]  c_BEAT_LAST  = c_BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [c_BEAT_W-1:0]  c_BEAT_ONE   = c_BEAT_W'(1);
  localparam logic [c_PULSE_W-1:0] c_PULSE_LAST = c_PULSE_W'(PULSE_CYCLES - 1);
  localparam logic [c_PULSE_W-1:0] c_PULSE_ONE  = c_PULSE_W'(1);
  localparam logic [c_WIN_W-1:0]   c_WIN_LAST   = c_WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [c_WIN_W-1:0]   c_WIN_ONE    = c_WIN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_FETCH  = 3'd2,
    S_SETTLE = 3'd3,
    S_ARMED  = 3'd4,
    S_GAP    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t               r_state;
  logic                 r_gen_get_move;
  logic                 r_gen_reset;
  logic [1:0]           r_target;
  logic                 r_last;
  logic                 r_target_valid;
  logic                 r_hit;
  logic                 r_miss;
  logic [7:0]           r_score;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_start_cnt;
  logic [c_BEAT_W-1:0]  r_beat_cnt;
  logic [c_PULSE_W-1:0] r_pulse_cnt;
  logic [c_WIN_W-1:0]   r_win_cnt;
  logic [3:0]           r_btn_q;

  logic [3:0] w_rise;
  logic       w_edge;
  logic       w_exact;
  logic       w_win_end;
  logic       w_beat_wrap;
  logic       w_start_go;
  logic       w_judge;
  logic       w_judge_hit;

  // A hit needs the target bit to be the only rising bit this cycle.
  assign w_rise      = btn & ~r_btn_q;
  assign w_edge      = |w_rise;
  assign w_exact     = (w_rise == (4'b0001 << r_target));
  assign w_win_end   = (r_win_cnt == c_WIN_LAST);
  assign w_beat_wrap = (r_beat_cnt == c_BEAT_LAST);
  assign w_start_go  = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_judge     = (r_state == S_ARMED) && (w_edge || w_win_end);
  assign w_judge_hit = w_judge && w_edge && w_exact;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_q <= 4'b0000;
    end else begin
      r_btn_q <= btn;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_gen_get_move <= 1'b0;
      r_gen_reset    <= 1'b1;
      r_target       <= 2'd0;
      r_last         <= 1'b0;
      r_target_valid <= 1'b0;
      r_hit          <= 1'b0;
      r_miss         <= 1'b0;
      r_score        <= 8'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_start_cnt    <= 1'b0;
      r_beat_cnt     <= '0;
      r_pulse_cnt    <= '0;
      r_win_cnt      <= '0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      if (r_state inside {S_FETCH, S_SETTLE, S_ARMED, S_GAP}) begin
        r_beat_cnt <= w_beat_wrap ? '0 : r_beat_cnt + c_BEAT_ONE;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          r_gen_reset <= 1'b0;
          if (r_state == S_DONE) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
          if (w_start_go) begin
            r_state     <= S_START;
            r_gen_reset <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_score     <= 8'd0;
            r_beat_cnt  <= '0;
            r_start_cnt <= 1'b0;
          end
        end
        S_START: begin
          if (!r_start_cnt) begin
            r_start_cnt <= 1'b1;
          end else begin
            r_state        <= S_FETCH;
            r_gen_reset    <= 1'b0;
            r_gen_get_move <= 1'b1;
            r_pulse_cnt    <= '0;
          end
        end
        S_FETCH: begin
          r_pulse_cnt <= r_pulse_cnt + c_PULSE_ONE;
          if (r_pulse_cnt == c_PULSE_LAST) begin
            r_gen_get_move <= 1'b0;
            r_state        <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_target       <= gen_move;
          r_last         <= gen_end;
          r_target_valid <= 1'b1;
          r_win_cnt      <= '0;
          r_state        <= S_ARMED;
        end
        S_ARMED: begin
          r_win_cnt <= r_win_cnt + c_WIN_ONE;
          if (w_judge) begin
            r_target_valid <= 1'b0;
            if (w_judge_hit) begin
              r_hit   <= 1'b1;
              r_score <= (r_score == 8'hFF) ? r_score : r_score + 8'd1;
            end else begin
              r_miss <= 1'b1;
            end
            r_state <= r_last ? S_DONE : S_GAP;
          end
        end
        S_GAP: begin
          if (w_beat_wrap) begin
            r_state        <= S_FETCH;
            r_gen_get_move <= 1'b1;
            r_pulse_cnt    <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MOVE_SCHED_COMBO_EN
  logic [7:0] r_combo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_combo <= 8'd0;
    end else if (w_start_go) begin
      r_combo <= 8'd0;
    end else if (w_judge) begin
      if (w_judge_hit) begin
        r_combo <= (r_combo == 8'hFF) ? r_combo : r_combo + 8'd1;
      end else begin
        r_combo <= 8'd0;
      end
    end
  end

  assign combo = r_combo;
`else
  assign combo = 8'd0;
`endif

  assign gen_get_move = r_gen_get_move;
  assign gen_reset    = r_gen_reset;
  assign target       = r_target;
  assign target_valid = r_target_valid;
  assign hit          = r_hit;
  assign miss         = r_miss;
  assign score        = r_score;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_scheduler
// Brief    : Scoreboard bench for move_scheduler with a 16-step move generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_scheduler;
  localparam int B = 32;
  localparam int P = 2;
  localparam int W = 8;
`ifdef MOVE_SCHED_COMBO_EN
  localparam bit COMBO_EN = 1'b1;
`else
  localparam bit COMBO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [1:0] gen_move;
  logic       gen_end;
  logic       gen_get_move, gen_reset, target_valid, hit, miss, busy, done;
  logic [1:0] target;
  logic [7:0] score, combo;

  always #5 clk = ~clk;

  move_scheduler #(
    .BEAT_CYCLES  (B),
    .PULSE_CYCLES (P),
    .WINDOW_CYCLES(W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .btn         (btn),
    .gen_move    (gen_move),
    .gen_end     (gen_end),
    .gen_get_move(gen_get_move),
    .gen_reset   (gen_reset),
    .target      (target),
    .target_valid(target_valid),
    .hit         (hit),
    .miss        (miss),
    .score       (score),
    .combo       (combo),
    .busy        (busy),
    .done        (done)
  );

  // Move generator: advances on each rising edge of gen_get_move.
  logic [1:0] tbl [16] = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd3, 2'd0,
                           2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd1, 2'd0, 2'd2};
  int   g_ptr;
  logic g_prev;
  always @(posedge clk) begin
    if (gen_reset) begin
      g_ptr    <= 0;
      g_prev   <= 1'b0;
      gen_move <= 2'd0;
      gen_end  <= 1'b0;
    end else begin
      g_prev <= gen_get_move;
      if (gen_get_move && !g_prev) begin
        gen_move <= tbl[g_ptr];
        gen_end  <= (g_ptr == 15);
        g_ptr    <= g_ptr + 1;
      end
    end
  end

  typedef struct {
    bit is_hit;
    int lat;
    int sc;
    int co;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tv_rise_cyc = 0;
  int   ggm_rise_cyc = 0;
  int   n_ggm = 0;
  logic tv_d = 1'b0;
  logic ggm_d = 1'b0;
  int   idx, exp_sc, exp_co;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: timing of target_valid and every hit/miss against the queue.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (gen_get_move && !ggm_d) begin
      ggm_rise_cyc = cyc;
      n_ggm++;
    end
    if (target_valid && !tv_d) begin
      tv_rise_cyc = cyc;
      chk("tv_rise_beat", cyc - ggm_rise_cyc, P + 1);
    end
    if (hit || miss) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL judge_unexpected hit=%0b miss=%0b score=%0d", hit, miss, score);
      end else begin
        e = q.pop_front();
        if (hit !== e.is_hit || miss !== !e.is_hit || (cyc - tv_rise_cyc) != e.lat ||
            int'(score) != e.sc || int'(combo) != e.co || target_valid !== 1'b0 ||
            busy !== 1'b1) begin
          errors++;
          $display("FAIL judge actual hit=%0b miss=%0b lat=%0d score=%0d combo=%0d tv=%0b busy=%0b required hit=%0b lat=%0d score=%0d combo=%0d tv=0 busy=1",
                   hit, miss, cyc - tv_rise_cyc, score, combo, target_valid, busy,
                   e.is_hit, e.lat, e.sc, e.co);
        end
      end
    end
    tv_d  = target_valid;
    ggm_d = gen_get_move;
  end

  task automatic chk_reset_vals(input string name);
    chk(name, int'({gen_get_move, gen_reset, target, target_valid, hit, miss,
                    score, combo, busy, done}),
        int'({1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}));
  endtask

  task automatic wait_tv(output bit ok);
    int t;
    t = 0;
    ok = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!target_valid && t < 4 * B);
    if (!target_valid) begin
      ok = 1'b0;
      chk("tv_timeout", 0, 1);
    end
  endtask

  // One hit window: press pat k cycles after target_valid rises (k<0: no press).
  task automatic win(input int k, input logic [3:0] pat, input bit rel);
    exp_t       e;
    logic [3:0] rise;
    logic [1:0] mv;
    bit         ok;
    int         t;
    wait_tv(ok);
    if (ok) begin
      mv = tbl[idx];
      idx++;
      chk("target", int'(target), int'(mv));
      rise = (k < 0) ? 4'b0000 : (pat & ~btn);
      if (rise == 4'b0000) begin
        e.is_hit = 1'b0;
        e.lat    = W;
      end else begin
        e.is_hit = (rise == (4'b0001 << mv));
        e.lat    = k + 1;
      end
      if (e.is_hit) begin
        exp_sc = (exp_sc == 255) ? 255 : exp_sc + 1;
        exp_co = (exp_co == 255) ? 255 : exp_co + 1;
      end else begin
        exp_co = 0;
      end
      e.sc = exp_sc;
      e.co = COMBO_EN ? exp_co : 0;
      q.push_back(e);
      if (k >= 0) begin
        repeat (k) @(negedge clk);
        btn = pat;
      end
      t = 0;
      while (!(hit || miss) && t < W + 4) begin
        @(negedge clk);
        t++;
      end
      if (rel) begin
        @(negedge clk);
        btn = 4'b0000;
      end
    end
  endtask

  task automatic song_start();
    idx    = 0;
    exp_sc = 0;
    exp_co = 0;
    n_ggm  = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_entry", int'({gen_reset, busy, done, score}), int'({1'b1, 1'b1, 1'b0, 8'd0}));
    @(negedge clk);
    chk("gen_reset_2nd", int'(gen_reset), 1);
    @(negedge clk);
    chk("fetch_entry", int'({gen_reset, gen_get_move}), int'({1'b0, 1'b1}));
  endtask

  task automatic song_end(input int sc, input int co);
    int t;
    t = 0;
    while (!done && t < 4 * B) begin
      @(negedge clk);
      t++;
    end
    chk("end_done_busy", int'({done, busy}), int'({1'b1, 1'b0}));
    chk("end_score", int'(score), sc);
    chk("end_combo", int'(combo), COMBO_EN ? co : 0);
    chk("end_ggm_pulses", n_ggm, 16);
    chk("end_queue_empty", q.size(), 0);
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_vals");
    reset_n = 1'b1;
    @(negedge clk);
    chk("gen_reset_release", int'(gen_reset), 0);
    repeat (2) @(negedge clk);

    // Song 1: hit every move two cycles into its window.
    song_start();
    for (int i = 0; i < 16; i++) win(2, 4'b0001 << tbl[i], 1'b1);
    song_end(16, 16);

    // Song 2: no presses at all.
    song_start();
    for (int i = 0; i < 16; i++) win(-1, 4'b0000, 1'b0);
    song_end(0, 0);

    // Song 3: wrong chord, last-window-cycle hit, ignored start, reset mid-song.
    song_start();
    win(2, 4'b0001 << tbl[0], 1'b1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    win(2, 4'b0001 << tbl[1], 1'b1);
    win(2, 4'b0001 << tbl[2], 1'b1);
    win(3, 4'b0011, 1'b1);
    chk("chord_score", int'(score), 3);
    win(W - 1, 4'b0001 << tbl[4], 1'b1);
    chk("combo_after_miss", int'(combo), COMBO_EN ? 1 : 0);
    win(2, 4'b0001 << tbl[5], 1'b1);
    wait_tv(ok);
    chk("move7_target", int'(target), int'(tbl[6]));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midsong_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("gen_reset_release2", int'(gen_reset), 0);
    chk("queue_after_reset", q.size(), 0);

    // Song 4: UP held into window 1, released, re-pressed in window 3.
    btn = 4'b0001;
    song_start();
    win(0, 4'b0001, 1'b0);
    win(-1, 4'b0000, 1'b0);
    @(negedge clk);
    btn = 4'b0000;
    win(2, 4'b0001, 1'b1);
    for (int i = 3; i < 16; i++) win(-1, 4'b0000, 1'b0);
    song_end(1, 0);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
